// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial deserializer: FSM state encodings and the
// width helper for the bit counter.
package serial_deserializer_pkg;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  // Bits needed to count 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_deserializer_sipo_shift_reg.sv
// Serial-in/parallel-out shift register with selectable bit order, a shift
// enable and a synchronous clear.
module sipo_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_next
);

  // MSB-first shifts left so the oldest bit ends in the top position.
  assign data_next = MSB_FIRST ? {data[WIDTH-2:0], din} : {din, data[WIDTH-1:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (shift_en) begin
      data <= data_next;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Assembles a serial bit stream into WIDTH-bit words presented through a
// one-word holding register on a valid/ready port.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            serial_in,
  input  logic                            serial_valid,
  output logic                            serial_ready,
  input  logic                            flush,
  output logic [WIDTH-1:0]                word_out,
  output logic                            word_valid,
  input  logic                            word_ready,
  output logic [count_width(WIDTH)-1:0]   bit_count,
  output logic                            state
);

  localparam int            CW   = count_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  // Handshakes: a transfer happens on a port only in a cycle where both its
  // valid and ready are high; valid never waits on ready, and word_out/word_valid
  // hold steady until the consumer takes the word.
  logic             beat;
  logic             drain;
  logic             slot_free;
  logic             shift_en;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] shift_data;
  logic [WIDTH-1:0] shift_next;

  assign serial_ready = (state == ST_FILL);
  assign beat         = serial_valid & serial_ready;
  assign drain        = word_valid & word_ready;
  assign slot_free    = !word_valid | word_ready;
  assign shift_en     = beat & !flush;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clock     (clock),
    .reset_n   (reset_n),
    .shift_en  (shift_en),
    .clear     (flush),
    .din       (serial_in),
    .data      (shift_data),
    .data_next (shift_next)
  );

  // A completing beat loads the combinational next value directly so the word
  // appears on the same edge that accepts its last bit.
  always_comb begin
    load      = 1'b0;
    load_data = shift_data;
    if (!flush) begin
      case (state)
        ST_FILL: begin
          if (beat && bit_count == LAST && slot_free) begin
            load      = 1'b1;
            load_data = shift_next;
          end
        end
        default: begin
          load = slot_free;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_FILL;
      bit_count <= '0;
    end else if (flush) begin
      state     <= ST_FILL;
      bit_count <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (beat) begin
            if (bit_count == LAST) begin
              if (slot_free) begin
                bit_count <= '0;
              end else begin
                state     <= ST_HOLD;
                bit_count <= FULL;
              end
            end else begin
              bit_count <= bit_count + CW'(1);
            end
          end
        end
        default: begin
          if (slot_free) begin
            state     <= ST_FILL;
            bit_count <= '0;
          end
        end
      endcase
    end
  end

  // Holding register: a load wins over a drain so back-to-back words have no bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (load) begin
      word_out   <= load_data;
      word_valid <= 1'b1;
    end else if (drain) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: MSB-first and LSB-first instances share one
// stimulus stream and are checked against a bit-queue reference model.
module tb_serial_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          serial_in = 1'b0;
  logic          serial_valid = 1'b0;
  logic          flush = 1'b0;
  logic          word_ready = 1'b0;

  logic          ready_m, ready_l, valid_m, valid_l, state_m, state_l;
  logic [W-1:0]  word_m, word_l;
  logic [CW-1:0] count_m, count_l;

  int checks = 0;
  int errors = 0;

  // reference model: accepted bits waiting in order, plus the holding register
  bit           m_bits[$];
  logic         m_hv = 1'b0;
  logic [W-1:0] m_hw_m = '0;
  logic [W-1:0] m_hw_l = '0;
  logic [W-1:0] exp_m_q[$];
  logic [W-1:0] exp_l_q[$];

  always #5 clock = ~clock;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in),
    .serial_valid(serial_valid), .serial_ready(ready_m), .flush(flush),
    .word_out(word_m), .word_valid(valid_m), .word_ready(word_ready),
    .bit_count(count_m), .state(state_m)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in),
    .serial_valid(serial_valid), .serial_ready(ready_l), .flush(flush),
    .word_out(word_l), .word_valid(valid_l), .word_ready(word_ready),
    .bit_count(count_l), .state(state_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = m_bits[i];
      else     w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_hv   = 1'b0;
    m_hw_m = '0;
    m_hw_l = '0;
    exp_m_q.delete();
    exp_l_q.delete();
  endtask

  task automatic model_step(input logic sv, input logic si, input logic fl, input logic wr);
    bit beat, drain, free, load;
    beat  = sv && (m_bits.size() < W);
    drain = m_hv && wr;
    free  = !m_hv || wr;
    load  = 1'b0;
    if (fl) begin
      m_bits.delete();
    end else begin
      if (beat) m_bits.push_back(si);
      if (m_bits.size() == W && free) load = 1'b1;
    end
    if (load) begin
      m_hw_m = pack(1'b1);
      m_hw_l = pack(1'b0);
      exp_m_q.push_back(m_hw_m);
      exp_l_q.push_back(m_hw_l);
      m_hv = 1'b1;
      m_bits.delete();
    end else if (drain) begin
      m_hv = 1'b0;
    end
  endtask

  task automatic check_outputs(input logic wr);
    logic full;
    full = (m_bits.size() == W);
    chk("ready_m", ready_m, !full);
    chk("ready_l", ready_l, !full);
    chk("count_m", count_m, m_bits.size());
    chk("count_l", count_l, m_bits.size());
    chk("state_m", state_m, full);
    chk("valid_m", valid_m, m_hv);
    chk("valid_l", valid_l, m_hv);
    chk("hold_m", word_m, m_hw_m);
    chk("hold_l", word_l, m_hw_l);
    if (m_hv && wr) begin
      if (exp_m_q.size() == 0 || exp_l_q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        chk("sb_word_m", word_m, exp_m_q.pop_front());
        chk("sb_word_l", word_l, exp_l_q.pop_front());
      end
    end
  endtask

  // Called at a falling edge: drive, check pre-edge state, advance model, step a cycle.
  task automatic tick(input logic sv, input logic si, input logic fl, input logic wr);
    serial_valid = sv;
    serial_in    = si;
    flush        = fl;
    word_ready   = wr;
    check_outputs(wr);
    model_step(sv, si, fl, wr);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic wr);
    for (int i = 0; i < W; i++) tick(1'b1, w[W-1-i], 1'b0, wr);
  endtask

  initial begin
    // reset held while bits are offered
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      serial_valid = 1'b1;
      serial_in    = 1'($urandom_range(0, 1));
      @(posedge clock);
      @(negedge clock);
      chk("rst_valid", valid_m, 0);
      chk("rst_count", count_m, 0);
      chk("rst_ready", ready_m, 1);
      chk("rst_word", word_m, 0);
    end
    model_reset();
    reset_n = 1'b1;

    // single word, MSB first
    send_word(8'b1011_0011, 1'b1);
    chk("t2_word", word_m, 8'hB3);
    chk("t2_valid", valid_m, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // back-to-back words with the consumer stalled
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    chk("t3_ready_low", ready_m, 0);
    chk("t3_word_a5", word_m, 8'hA5);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_word_3c", word_m, 8'h3C);
    chk("t3_ready_high", ready_m, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // continuous stream of four words
    for (int k = 0; k < 4; k++) send_word(8'($urandom), 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // flush discards a partial word
    for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    send_word(8'hFF, 1'b1);
    chk("t5_word_ff", word_m, 8'hFF);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_flush_beat", count_m, 0);

    // LSB-first ordering
    send_word(8'b1000_0000, 1'b1);
    chk("t6_word_lsb", word_l, 8'h01);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    // reset while holding a completed word
    send_word(8'h5A, 1'b0);
    send_word(8'hC3, 1'b0);
    chk("t6_hold", state_m, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_state", state_m, 0);
    chk("t6_rst_valid", valid_m, 0);
    chk("t6_rst_count", count_l, 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
